// File: rtl/i2c_target.sv
// ----------------------------------------------------------------------------
// i2c_target
//   I2C target (slave) with a 7-bit address. It oversamples SCL/SDA with the
//   system clock, ACKs its own address, delivers written bytes on wr_data/
//   wr_valid and fetches read bytes through the rd_req/rd_data handshake.
//   SDA is driven open-drain through sda_oe. SCL is never driven, so clock
//   stretching is not supported.
//
// Parameters
//   ADDR         7-bit address this target answers to
//   SYNC_STAGES  synchronizer depth for scl_i/sda_i (2..4)
//
// Ports
//   clk       system clock, at least 20x the SCL rate
//   rst       asynchronous active-high reset
//   scl_i     I2C SCL line (asynchronous)
//   sda_i     I2C SDA line (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   wr_data   last byte received in a write transfer
//   wr_valid  one-clock pulse, wr_data valid in the same cycle
//   rd_data   next byte to transmit, sampled in the rd_req cycle
//   rd_req    one-clock pulse requesting the next read byte
//   busy      high from START detection to STOP detection
// ----------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] wr_data,
    output logic       wr_valid,
    input  logic [7:0] rd_data,
    output logic       rd_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_DATA  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    // Synchronizer chains plus one extra flop each for edge detection.
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    logic scl_s;
    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_valid_q, wr_valid_d;
    logic       rd_req_q, rd_req_d;
    logic       busy_q, busy_d;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Bus events, all derived from the synchronized lines. START/STOP need
    // SCL high in both the current and previous sample so that an SDA change
    // racing an SCL edge is not mistaken for a bus condition.
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_s & scl_prev_q;
    assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign sda_oe   = sda_oe_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign rd_req   = rd_req_q;
    assign busy     = busy_q;

    // Next value of the synchronizer chains and edge-detect history.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Synchronizer registers; reset to 1 so the bus looks idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    // Protocol FSM: next state and next values of every protocol register.
    // sda_oe is only ever changed on an SCL falling edge (or forced low by
    // START/STOP), so it is stable while SCL is high.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy_q;

        // The byte requested last cycle is loaded into the TX shifter. An
        // SCL edge never lands in this cycle, so the shift below cannot clash.
        if (rd_req_q) begin
            tx_d = rd_data;
        end else begin
            tx_d = tx_q;
        end

        if (stop_s) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_s) begin
            // Any partial byte is simply abandoned: counter and state restart.
            state_d   = S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise_s) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            // shift_q[6:0] holds the address, sda_s is R/W.
                            bit_cnt_d = 4'd0;
                            if (shift_q[6:0] == ADDR) begin
                                state_d  = S_ADDR_ACK;
                                rw_d     = sda_s;
                                rd_req_d = sda_s;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                S_ADDR_ACK: begin
                    // Fall after bit 8 pulls SDA; rise of bit 9 hands over to
                    // the data state, whose next fall releases or drives SDA.
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b1;
                    end else if (scl_rise_s) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            state_d = S_RD_DATA;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_WR_DATA: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise_s) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            wr_data_d  = {shift_q[6:0], sda_s};
                            wr_valid_d = 1'b1;
                            bit_cnt_d  = 4'd0;
                            state_d    = S_WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_d = 1'b1;
                    end else if (scl_rise_s) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_WR_DATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RD_DATA: begin
                    // Entered at the ACK rising edge with count 0; the
                    // following fall puts out the MSB. Eight bits later the
                    // fall releases SDA for the master's ACK/NACK.
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end else if (scl_rise_s) begin
                        if (bit_cnt_q != 4'd8) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = 4'd0;
                        if (!sda_s) begin
                            state_d  = S_RD_DATA;
                            rd_req_d = 1'b1;
                        end else begin
                            state_d  = S_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = 1'b0;
                end
            endcase
        end
    end

    // Protocol registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_data_q  <= 8'h00;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// ----------------------------------------------------------------------------
// tb_i2c_target
//   Bench for i2c_target: a bus-functional I2C master drives SCL/SDA, a
//   scoreboard keeps expected write bytes and expected read bytes, and each
//   scenario task compares what it observes against the scoreboard.
// ----------------------------------------------------------------------------
module tb_i2c_target;

    localparam int Q = 100;  // quarter SCL period; SCL period = 40 clk

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic [7:0] rd_data;
    logic       rd_req;
    logic       busy;

    // Scoreboard state.
    logic [7:0] exp_wr_q[$];
    logic [7:0] obs_wr_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] rd_src[0:15];
    logic [3:0] rd_idx = 4'd0;
    int         rd_cnt = 0;
    int         oe_high_cnt = 0;
    int         oe_glitch = 0;
    logic       scl_last = 1'b1;
    logic       oe_last = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    // Open-drain bus: low if either side pulls it.
    assign sda_bus = sda_m & ~sda_oe;
    assign rd_data = rd_src[rd_idx];

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .rd_data  (rd_data),
        .rd_req   (rd_req),
        .busy     (busy)
    );

    // Read-byte provider: on every rd_req the presented byte becomes an
    // expected master-received byte and the next source byte is presented.
    always @(posedge clk) begin
        if (rd_req) begin
            exp_rx_q.push_back(rd_src[rd_idx]);
            rd_idx <= rd_idx + 4'd1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Output monitor: capture write bytes, count cycles with SDA pulled,
    // and count sda_oe changes while SCL is high.
    always @(negedge clk) begin
        if (wr_valid) obs_wr_q.push_back(wr_data);
        if (sda_oe) oe_high_cnt <= oe_high_cnt + 1;
        if (!rst && scl_m && scl_last && (sda_oe !== oe_last)) oe_glitch <= oe_glitch + 1;
        scl_last <= scl_m;
        oe_last  <= sda_oe;
    end

    // ---------------- master bus-functional tasks ----------------
    task automatic bus_start();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #(Q);
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b, output logic oe);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b  = sda_bus;
        oe = sda_oe;
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic oe;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack, oe);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack, output logic oe_at_ack);
        logic b, oe;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b, oe);
            d[i] = b;
        end
        sda_m = nack; #(Q);
        scl_m = 1'b1; #(Q);
        oe_at_ack = sda_oe;
        #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        #20;
        n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else n_pass++;
        n_checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h expected 00", wr_data); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); else n_pass++;
        n_checks++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req: got %b expected 0", rd_req); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_write();
        logic ack;
        exp_wr_q.push_back(8'h74);
        bus_start();
        n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_start: got %b expected 1", busy); else n_pass++;
        write_byte(8'h54, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b expected 0", ack); else n_pass++;
        write_byte(8'h74, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL wr_data_ack: got %b expected 0", ack); else n_pass++;
        bus_stop();
        #(Q);
        n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size())
            $display("FAIL wr_count: got %0d pulses expected %0d", obs_wr_q.size(), exp_wr_q.size());
        else n_pass++;
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_wr_q.pop_front();
            o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL wr_byte: got %h expected %h", o, e); else n_pass++;
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        n_checks++; if (wr_data !== 8'h74) $display("FAIL wr_data_hold: got %h expected 74", wr_data); else n_pass++;
    endtask

    task automatic test_read_single();
        logic ack, oe;
        logic [7:0] d, e;
        int c0;
        c0 = rd_cnt;
        rd_src[rd_idx] = 8'hA5;
        bus_start();
        write_byte(8'h55, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL rd1_addr_ack: got %b expected 0", ack); else n_pass++;
        read_byte(d, 1'b1, oe);
        n_checks++;
        if (exp_rx_q.size() == 0) $display("FAIL rd1_byte: got %h expected a requested byte", d);
        else begin
            e = exp_rx_q.pop_front();
            if (d !== e) $display("FAIL rd1_byte: got %h expected %h", d, e); else n_pass++;
        end
        n_checks++; if (oe !== 1'b0) $display("FAIL rd1_release: got sda_oe %b expected 0", oe); else n_pass++;
        bus_stop();
        #(Q);
        n_checks++; if (rd_cnt - c0 != 1) $display("FAIL rd1_req_count: got %0d expected 1", rd_cnt - c0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rd1_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_read_multi();
        logic ack, oe;
        logic [7:0] d, e;
        logic [3:0] k;
        int c0;
        c0 = rd_cnt;
        k = rd_idx;
        rd_src[k] = 8'h01; k = k + 4'd1;
        rd_src[k] = 8'h02; k = k + 4'd1;
        rd_src[k] = 8'h03;
        bus_start();
        write_byte(8'h55, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL rd3_addr_ack: got %b expected 0", ack); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            read_byte(d, (i == 2) ? 1'b1 : 1'b0, oe);
            n_checks++;
            if (exp_rx_q.size() == 0) $display("FAIL rd3_byte%0d: got %h expected a requested byte", i, d);
            else begin
                e = exp_rx_q.pop_front();
                if (d !== e) $display("FAIL rd3_byte%0d: got %h expected %h", i, d, e); else n_pass++;
            end
        end
        bus_stop();
        #(Q);
        n_checks++; if (rd_cnt - c0 != 3) $display("FAIL rd3_req_count: got %0d expected 3", rd_cnt - c0); else n_pass++;
    endtask

    task automatic test_addr_mismatch();
        logic ack;
        int c0;
        c0 = oe_high_cnt;
        bus_start();
        write_byte(8'h2A, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL nm_addr_ack: got %b expected 1", ack); else n_pass++;
        write_byte(8'h74, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL nm_data_ack: got %b expected 1", ack); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL nm_busy: got %b expected 1", busy); else n_pass++;
        bus_stop();
        #(Q);
        n_checks++; if (oe_high_cnt != c0) $display("FAIL nm_sda_oe: got %0d driven cycles expected 0", oe_high_cnt - c0); else n_pass++;
        n_checks++; if (obs_wr_q.size() != 0) $display("FAIL nm_wr_valid: got %0d pulses expected 0", obs_wr_q.size()); else n_pass++;
        obs_wr_q.delete();
        n_checks++; if (busy !== 1'b0) $display("FAIL nm_busy_stop: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_partial_restart();
        logic ack, oe;
        logic [7:0] d, e;
        rd_src[rd_idx] = 8'h3C;
        bus_start();
        write_byte(8'h54, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL pr_addr_ack: got %b expected 0", ack); else n_pass++;
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b1);
        bus_start();
        write_byte(8'h55, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL pr_rd_addr_ack: got %b expected 0", ack); else n_pass++;
        read_byte(d, 1'b1, oe);
        n_checks++;
        if (exp_rx_q.size() == 0) $display("FAIL pr_rd_byte: got %h expected a requested byte", d);
        else begin
            e = exp_rx_q.pop_front();
            if (d !== e) $display("FAIL pr_rd_byte: got %h expected %h", d, e); else n_pass++;
        end
        bus_stop();
        #(Q);
        n_checks++; if (obs_wr_q.size() != 0) $display("FAIL pr_wr_valid: got %0d pulses expected 0", obs_wr_q.size()); else n_pass++;
        obs_wr_q.delete();
    endtask

    task automatic test_back_to_back();
        logic ack;
        logic [7:0] bytes [0:2];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'hC3;
        for (int i = 0; i < 3; i++) exp_wr_q.push_back(bytes[i]);
        bus_start();
        write_byte(8'h54, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL b2b_addr_ack: got %b expected 0", ack); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            write_byte(bytes[i], ack);
            n_checks++; if (ack !== 1'b0) $display("FAIL b2b_ack%0d: got %b expected 0", i, ack); else n_pass++;
        end
        bus_stop();
        #(Q);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size())
            $display("FAIL b2b_count: got %0d pulses expected %0d", obs_wr_q.size(), exp_wr_q.size());
        else n_pass++;
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_wr_q.pop_front();
            o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL b2b_byte: got %h expected %h", o, e); else n_pass++;
        end
        exp_wr_q.delete(); obs_wr_q.delete();
    endtask

    task automatic test_reset_mid_ack();
        logic ack, b, oe;
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h54 >> i));
        // SCL is low and the target is holding the address ACK.
        n_checks++; if (sda_oe !== 1'b1) $display("FAIL rst_ack_driven: got %b expected 1", sda_oe); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (sda_oe !== 1'b0) $display("FAIL rst_async_release: got %b expected 0", sda_oe); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        read_bit(b, oe);
        n_checks++; if (b !== 1'b1) $display("FAIL rst_ignore_ack: got %b expected 1", b); else n_pass++;
        bus_stop();
        #(Q);
        exp_wr_q.push_back(8'h74);
        bus_start();
        write_byte(8'h54, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL rst_wr_addr_ack: got %b expected 0", ack); else n_pass++;
        write_byte(8'h74, ack);
        n_checks++; if (ack !== 1'b0) $display("FAIL rst_wr_data_ack: got %b expected 0", ack); else n_pass++;
        bus_stop();
        #(Q);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size())
            $display("FAIL rst_wr_count: got %0d pulses expected %0d", obs_wr_q.size(), exp_wr_q.size());
        else n_pass++;
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_wr_q.pop_front();
            o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL rst_wr_byte: got %h expected %h", o, e); else n_pass++;
        end
        exp_wr_q.delete(); obs_wr_q.delete();
    endtask

    task automatic test_oe_stability();
        n_checks++; if (oe_glitch != 0) $display("FAIL oe_stable_scl_high: got %0d changes expected 0", oe_glitch); else n_pass++;
        n_checks++; if (exp_rx_q.size() != 0) $display("FAIL rd_unconsumed: got %0d extra requested bytes expected 0", exp_rx_q.size()); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rd_src[i] = 8'h00;
        test_reset();
        test_write();
        test_read_single();
        test_read_multi();
        test_addr_mismatch();
        test_partial_restart();
        test_back_to_back();
        test_reset_mid_ack();
        test_oe_stability();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h2A, is the 7-bit target address this block responds to.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth for scl_i/sda_i; legal range 2..4.
REQ-003 clk  input  1  system clock; one clock; frequency SHALL be >= 20x SCL rate.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 scl_i  input  1  I2C SCL line, asynchronous to clk.
REQ-006 sda_i  input  1  I2C SDA line, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 wr_data  output  8  last byte received in a write transfer.
REQ-009 wr_valid  output  1  one-clk pulse; wr_data is valid in the same cycle.
REQ-010 rd_data  input  8  byte to transmit; sampled in the cycle of rd_req.
REQ-011 rd_req  output  1  one-clk pulse requesting the next read byte.
REQ-012 busy  output  1  high from START detection to STOP detection, regardless of address match.

Function
REQ-013 scl_i/sda_i SHALL pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized values.
REQ-014 START/repeated START: synchronized SDA falls while SCL high -> state ADDR, bit count 0, from any state.
REQ-015 STOP: synchronized SDA rises while SCL high -> state IDLE, sda_oe=0, busy=0, from any state.
REQ-016 Data bits SHALL be sampled on the synchronized SCL rising edge, MSB first.
REQ-017 sda_oe SHALL change only in the cycle after a synchronized SCL falling edge; it SHALL be stable while SCL is high.
REQ-018 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-019 ADDR: shift 8 bits (7 address + R/W). If addr==ADDR -> ADDR_ACK. Otherwise -> IGNORE with sda_oe=0 until START/STOP.
REQ-020 ADDR_ACK: sda_oe=1 from the falling edge after bit 8 to the falling edge after bit 9. Then -> WR_DATA if R/W=0, or -> RD_DATA if R/W=1.
REQ-021 WR_DATA: on the 8th rising edge, wr_data <= shifted byte and wr_valid pulses for exactly one clk, 1 cycle after the edge is detected; -> WR_ACK.
REQ-022 WR_ACK: drive ACK as in REQ-020, then -> WR_DATA; the write byte count is unbounded.
REQ-023 Read entry: rd_req pulses one clk in the cycle ADDR_ACK is entered (R/W=1), and again in the cycle RD_ACK samples ACK=0. rd_data is latched into the TX shifter on the next clk.
REQ-024 RD_DATA: on each SCL falling edge (including the one ending the ACK), sda_oe = ~tx_bit, MSB first. After the 8th bit's falling edge, sda_oe=0 -> RD_ACK.
REQ-025 RD_ACK: sample SDA on the 9th rising edge. 0 -> RD_DATA with the next byte. 1 (NACK) -> IGNORE, sda_oe=0.
REQ-026 A START or STOP mid-byte SHALL discard the partial byte; no wr_valid is produced for it.
REQ-027 Bit counter is 4 bits, counts 0..8, and resets at each byte/ACK boundary; no wrap beyond 8.
REQ-028 SCL is never driven; clock stretching is not supported.

Reset
REQ-029 While rst=1: state=IDLE, sda_oe=0, wr_data=8'h00, wr_valid=0, rd_req=0, busy=0, and synchronizers are set to 1 (idle bus).
REQ-030 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously). After release, the block SHALL ignore bus activity until the next START.

Verification
REQ-031 Write 0x2A (W), then byte 0x74, then STOP -> both ACKs are driven; wr_valid pulses exactly once with wr_data=0x74; busy returns to 0.
REQ-032 Read from 0x2A with rd_data=0xA5, master NACKs -> master samples 0xA5; rd_req pulses once; SDA is released after the 8th bit.
REQ-033 Read 3 bytes (rd_data 0x01, 0x02, 0x03 on successive rd_req), master ACK, ACK, NACK -> master receives 0x01, 0x02, 0x03; rd_req pulses 3 times.
REQ-034 Address 0x15 (W) followed by 0x74 -> sda_oe stays 0 throughout; wr_valid is never asserted.
REQ-035 Write 0x2A, partial byte (4 bits), then repeated START plus read 0x2A with rd_data=0x3C -> no wr_valid; read returns 0x3C.
REQ-036 Assert rst during an ACK bit while sda_oe=1 -> sda_oe=0 in the same cycle; a subsequent full write of 0x2A/0x74 completes normally.
